// File: rtl/exec_pkg.sv
// Shared execute-stage constants for the multiply/divide sequencer.
package exec_pkg;

    // R-type opcode and the two ALU ops routed to the iterative unit
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // Exception codes written to the rstatus register
    localparam int unsigned RSTATUS_MUL_OVF  = 4;
    localparam int unsigned RSTATUS_DIV_ZERO = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWb   = 2'd2
    } md_state_e;

endpackage

// File: rtl/multdiv_iter_core.sv
// Iterative unsigned datapath: shift-add multiplier and restoring divider,
// one result bit per cycle on magnitudes latched at start.
module multdiv_iter_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               op_div_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   mag_a_i,
    input  logic [WIDTH-1:0]   mag_b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned CntW = $clog2(ITER + 1);

    logic             active_q;
    logic             op_div_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q;   // product high half, or partial remainder
    logic [WIDTH-1:0] lo_q;   // multiplier being consumed, or dividend -> quotient
    logic [WIDTH-1:0] b_q;    // multiplicand or divisor

    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    // One iteration step; result_o is the value the registers take on this edge
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        if (op_div_q) begin
            hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        done_o   = active_q && (cnt_q == CntW'(ITER - 1));
        result_o = op_div_q ? {{WIDTH{1'b0}}, lo_d} : {hi_d, lo_d};
    end

    // Operand latch, iteration counter and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            op_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            op_div_q <= op_div_i;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= mag_a_i;
            b_q      <= mag_b_i;
        end else if (active_q) begin
            if (abort_i) begin
                active_q <= 1'b0;
            end else begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CntW'(1);
                if (done_o) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer for multi-cycle signed mul/div: owns the FSM, sign and
// exception handling, pipeline stall and the handshaked register-file write.
module multdiv_controller
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ITER         = 32,
    parameter int unsigned RSTATUS_REG  = 30,
    parameter int unsigned MUL_EXC_CODE = RSTATUS_MUL_OVF,
    parameter int unsigned DIV_EXC_CODE = RSTATUS_DIV_ZERO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_valid,
    input  logic [4:0]       opcode,
    input  logic [4:0]       ALU_op,
    input  logic [4:0]       rd,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             wb_valid,
    output logic [4:0]       wb_reg,
    output logic [WIDTH-1:0] wb_data,
    input  logic             wb_ready
);

    md_state_e        state_q;
    logic             op_div_q;
    logic             neg_q;
    logic [4:0]       rd_q;
    logic             wb_valid_q;
    logic [4:0]       wb_reg_q;
    logic [WIDTH-1:0] wb_data_q;

    logic               is_md;
    logic               is_div;
    logic               start;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               core_done;
    logic [2*WIDTH-1:0] core_result;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH:0]     prod_upper;
    logic [WIDTH-1:0]   quot_signed;
    logic               mul_ovf;
    logic [4:0]         fin_reg;
    logic [WIDTH-1:0]   fin_data;

    // Instruction decode, operand magnitudes and stall
    always_comb begin
        is_md    = x_valid && (opcode == OPC_RTYPE) && (ALU_op == ALU_MUL || ALU_op == ALU_DIV);
        is_div   = (ALU_op == ALU_DIV);
        start    = (state_q == StIdle) && is_md && !flush;
        div_zero = is_div && (operandB == '0);
        mag_a    = operandA[WIDTH-1] ? -operandA : operandA;
        mag_b    = operandB[WIDTH-1] ? -operandB : operandB;
        // Drops on the write cycle and on a flush so X can advance
        stall    = start
                || (state_q == StRun && !flush)
                || (state_q == StWb && !wb_ready && !flush);
        busy     = (state_q != StIdle);
    end

    multdiv_iter_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk_i    (clock),
        .rst_ni   (reset),
        .start_i  (start && !div_zero),
        .op_div_i (is_div),
        .abort_i  (flush && state_q == StRun),
        .mag_a_i  (mag_a),
        .mag_b_i  (mag_b),
        .done_o   (core_done),
        .result_o (core_result)
    );

    // Sign fix-up and overflow detection on the final core result
    always_comb begin
        prod_signed = neg_q ? -core_result : core_result;
        quot_signed = neg_q ? -core_result[WIDTH-1:0] : core_result[WIDTH-1:0];
        prod_upper  = prod_signed[2*WIDTH-1:WIDTH-1];
        // Fits in WIDTH signed bits only if the top WIDTH+1 bits are a sign extension
        mul_ovf     = !((&prod_upper) || !(|prod_upper));
        fin_reg     = rd_q;
        fin_data    = quot_signed;
        if (!op_div_q) begin
            if (mul_ovf) begin
                fin_reg  = 5'(RSTATUS_REG);
                fin_data = WIDTH'(MUL_EXC_CODE);
            end else begin
                fin_data = prod_signed[WIDTH-1:0];
            end
        end
    end

    // Sequencer FSM with registered writeback outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_div_q <= is_div;
                        neg_q    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        rd_q     <= rd;
                        if (div_zero) begin
                            state_q    <= StWb;
                            wb_valid_q <= 1'b1;
                            wb_reg_q   <= 5'(RSTATUS_REG);
                            wb_data_q  <= WIDTH'(DIV_EXC_CODE);
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (core_done) begin
                        state_q    <= StWb;
                        wb_valid_q <= 1'b1;
                        wb_reg_q   <= fin_reg;
                        wb_data_q  <= fin_data;
                    end
                end
                StWb: begin
                    // Flush takes priority over a grant: no write happens
                    if (flush || wb_ready) begin
                        state_q    <= StIdle;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;

endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
- Sequences multi-cycle signed multiply and divide (R-type, opcode 00000, ALU_op 00110 mul / 00111 div) issued in the execute stage.
- Latches the operands and runs an iterative shift-add multiplier or restoring divider.
- Stalls fetch/decode/execute while busy.
- Writes the result, or the rstatus exception code, through a handshaked register-file write port shared with the writeback stage.

Parameters:
- WIDTH, 32, operand/result width.
- ITER, 32, iteration cycles in RUN (one result bit per cycle).
- RSTATUS_REG, 30, register written with the exception code.
- MUL_EXC_CODE, 4, rstatus value on multiply overflow.
- DIV_EXC_CODE, 5, rstatus value on divide by zero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- x_valid  in  1  execute stage holds a valid instruction.
- opcode  in  5  execute-stage opcode.
- ALU_op  in  5  execute-stage ALU op.
- rd  in  5  destination register.
- operandA  in  WIDTH  rs value (multiplicand / dividend).
- operandB  in  WIDTH  rt value (multiplier / divisor).
- flush  in  1  abort the in-flight operation (pipeline squash).
- stall  out  1  hold F/D/X pipeline registers.
- busy  out  1  state != IDLE.
- wb_valid  out  1  write request.
- wb_reg  out  5  write address.
- wb_data  out  WIDTH  write data.
- wb_ready  in  1  write port granted this cycle.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; stall=0, busy=0, wb_valid=0, wb_reg=0, wb_data=0, counter=0. Overrides every state, including mid-operation; an aborted operation produces no write.
- start = x_valid & opcode==00000 & (ALU_op==00110 | ALU_op==00111) & ~flush, evaluated only in IDLE.
- States: IDLE, RUN, WB.
- IDLE:
  - On start: latch |A|, |B|, result sign, op, rd; clear counter.
  - Divisor==0 on div: go straight to WB with wb_reg=RSTATUS_REG, wb_data=DIV_EXC_CODE.
  - Otherwise go to RUN.
- RUN:
  - Counter increments each cycle; exactly ITER cycles.
  - On the last cycle, compute the final signed result and go to WB.
  - Inputs opcode/ALU_op/operands are ignored while RUN/WB (the instruction is held in X by stall).
- WB:
  - wb_valid=1 with wb_reg/wb_data stable until wb_ready.
  - Cycle with wb_ready=1: write occurs, next state IDLE.
  - wb_valid, wb_reg and wb_data are registered outputs.
- stall (combinational) = (IDLE & start) | RUN | (WB & ~wb_ready).
  - Drops in the accept cycle so X advances; the same instruction never retriggers.
- Latency: start at cycle T.
  - RUN occupies T+1..T+ITER.
  - wb_valid first high at T+ITER+1.
  - Divide by zero: wb_valid at T+1.
- Multiply:
  - 2*WIDTH-bit magnitude product, negated if signs differ.
  - Overflow when the upper WIDTH+1 bits are not all equal; then write RSTATUS_REG=MUL_EXC_CODE and leave rd unwritten.
  - Otherwise write the low WIDTH bits to rd.
- Divide:
  - Signed quotient truncated toward zero; remainder discarded.
  - INT_MIN / -1 yields 0x80000000 with no exception.
- rd==0: handshake still performed with wb_reg=0 (regfile ignores r0); exceptions always target RSTATUS_REG.
- flush:
  - In RUN or WB: next state IDLE, wb_valid=0, no write; stall=0 in the flush cycle.
  - In IDLE: suppresses start.
- Simultaneous wb_ready & flush in WB: flush wins, no write.

Decomposition:
- Shared package (exec_pkg):
  - Opcode/ALU_op constants (OPC_RTYPE, ALU_MUL, ALU_DIV).
  - RSTATUS codes.
  - State enum {IDLE, RUN, WB}.
- Sub-module multdiv_iter_core:
  - Owns the magnitude registers, iteration counter, and shift-add / restoring-divide datapath.
  - Interface: start/op/operands in, done + raw 2*WIDTH product or quotient out.
- The controller keeps the FSM, sign/exception handling, stall and writeback handshake.

Test Plan:
- mul 7 * -6, rd=3, wb_ready tied 1, start T → stall high T..T+32, wb_valid only at T+33, wb_reg=3, wb_data=0xFFFFFFD6, stall low T+33.
- mul 0x00010000 * 0x00010000, rd=4 → at T+33 wb_reg=30, wb_data=4; r4 never written.
- div 100 / -7, rd=5 → T+33 wb_data=0xFFFFFFF2 (-14); then div 0x80000000 / 0xFFFFFFFF → wb_data=0x80000000, wb_reg=rd.
- div 9 / 0, rd=6 → no RUN, wb_valid at T+1, wb_reg=30, wb_data=5, single stall cycle at T.
- mul completes with wb_ready low for 3 cycles → wb_valid/wb_reg/wb_data constant, stall high until the ready cycle, then IDLE; the held instruction does not restart.
- flush at RUN cycle 10, then separately reset=0 at RUN cycle 20 → next cycle IDLE, stall=0, busy=0, no wb_valid ever for that op; a new mul issued afterwards completes normally at its T+33.
